// File: rtl/dm_rr_access_ctrl_if.sv
// Core-side request bus and RAM-side port bundle for dm_rr_access_ctrl.
// The controller uses the slave view; the cores/RAM environment uses the master view.
interface dm_rr_access_ctrl_if #(
    parameter int NCORES = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [NCORES-1:0]        req_rd;
    logic [NCORES-1:0]        req_wr;
    logic [NCORES*ADDR_W-1:0] core_addr;
    logic [NCORES*DATA_W-1:0] core_wdata;
    logic [NCORES-1:0]        ack;
    logic [NCORES*DATA_W-1:0] core_rdata;
    logic                     mem_rd;
    logic                     mem_wr;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic [DATA_W-1:0]        mem_rdata;
    logic                     busy;

    modport slave (
        input  req_rd, req_wr, core_addr, core_wdata, mem_rdata,
        output ack, core_rdata, mem_rd, mem_wr, mem_addr, mem_wdata, busy
    );

    modport master (
        output req_rd, req_wr, core_addr, core_wdata, mem_rdata,
        input  ack, core_rdata, mem_rd, mem_wr, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/dm_rr_access_ctrl.sv
// Round-robin arbiter/sequencer giving NCORES cores read/write access to one single-port RAM.
// Optional read coalescing of same-address readers is enabled by defining DM_COALESCE_EN.
//
//  state | meaning
//  IDLE  | waiting; grants first requester at/after the rr pointer
//  ISSUE | mem_rd or mem_wr strobe is on the RAM port
//  WAIT  | counting down RD_LAT cycles for read data
//  RESP  | ack pulse to the served core(s), pointer advances
module dm_rr_access_ctrl #(
    parameter int NCORES = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input logic               clk,
    input logic               rst,
    dm_rr_access_ctrl_if.slave bus
);

    localparam int ID_W  = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NCORES - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     gnt_id;
    logic                op_wr;
    logic [NCORES-1:0]   mbr;
    logic [CNT_W-1:0]    cnt;
    logic [NCORES-1:0]   ack_q;
    logic                mem_rd_q;
    logic                mem_wr_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                busy_q;
    logic [DATA_W-1:0]   rdata_q [NCORES];

    logic [NCORES-1:0]        req_any;
    logic [ADDR_W-1:0]        addr_arr  [NCORES];
    logic [DATA_W-1:0]        wdata_arr [NCORES];
    logic                     gnt_found;
    logic [ID_W-1:0]          gnt_sel;
    logic [ID_W-1:0]          idx;
    logic                     gnt_wr;
    logic [NCORES-1:0]        gnt_mask;
    logic [NCORES*DATA_W-1:0] rdata_flat;

    assign req_any = bus.req_rd | bus.req_wr;

    always_comb begin
        for (int i = 0; i < NCORES; i++) begin
            addr_arr[i]  = bus.core_addr[i*ADDR_W +: ADDR_W];
            wdata_arr[i] = bus.core_wdata[i*DATA_W +: DATA_W];
        end
    end

    // Cyclic priority search starting at the pointer.
    always_comb begin
        gnt_found = 1'b0;
        gnt_sel   = '0;
        idx       = '0;
        for (int k = 0; k < NCORES; k++) begin
            idx = ID_W'((int'(ptr) + k) % NCORES);
            if (!gnt_found && req_any[idx]) begin
                gnt_found = 1'b1;
                gnt_sel   = idx;
            end
        end
    end

    // A core asserting both requests gets its write served.
    assign gnt_wr = bus.req_wr[gnt_sel];

    always_comb begin
        gnt_mask          = '0;
        gnt_mask[gnt_sel] = 1'b1;
`ifdef DM_COALESCE_EN
        if (!gnt_wr) begin
            for (int i = 0; i < NCORES; i++) begin
                if (bus.req_rd[i] && !bus.req_wr[i] && (addr_arr[i] == addr_arr[gnt_sel]))
                    gnt_mask[i] = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            gnt_id      <= '0;
            op_wr       <= 1'b0;
            mbr         <= '0;
            cnt         <= '0;
            ack_q       <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            for (int i = 0; i < NCORES; i++) rdata_q[i] <= '0;
        end else begin
            ack_q    <= '0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        gnt_id      <= gnt_sel;
                        op_wr       <= gnt_wr;
                        mbr         <= gnt_mask;
                        mem_addr_q  <= addr_arr[gnt_sel];
                        mem_wdata_q <= wdata_arr[gnt_sel];
                        mem_wr_q    <= gnt_wr;
                        mem_rd_q    <= ~gnt_wr;
                        busy_q      <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (op_wr) begin
                        ack_q <= mbr;
                        state <= RESP;
                    end else begin
                        cnt   <= CNT_INIT;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        for (int i = 0; i < NCORES; i++) begin
                            if (mbr[i]) rdata_q[i] <= bus.mem_rdata;
                        end
                        ack_q <= mbr;
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    ptr    <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rdata_flat = '0;
        for (int i = 0; i < NCORES; i++) rdata_flat[i*DATA_W +: DATA_W] = rdata_q[i];
    end

    assign bus.ack        = ack_q;
    assign bus.core_rdata = rdata_flat;
    assign bus.mem_rd     = mem_rd_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_dm_rr_access_ctrl.sv
// Scoreboard bench for dm_rr_access_ctrl with a RAM model of read latency RL.
// Build with DM_COALESCE_EN defined to exercise read coalescing expectations.
module tb_dm_rr_access_ctrl;
    localparam int NC = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int RL = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dm_rr_access_ctrl_if #(.NCORES(NC), .ADDR_W(AW), .DATA_W(DW)) bus ();

    dm_rr_access_ctrl #(.NCORES(NC), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM model: unwritten words read as 0x5A00 ^ addr
    bit   [15:0] wval  [256];
    bit          wflag [256];
    logic [15:0] pipe  [RL];

    function automatic logic [15:0] ram_rd(input logic [7:0] a);
        return wflag[a] ? wval[a] : (16'h5A00 ^ {8'h00, a});
    endfunction

    always @(posedge clk) begin
        if (bus.mem_wr === 1'b1) begin
            wval[bus.mem_addr[7:0]]  <= bus.mem_wdata;
            wflag[bus.mem_addr[7:0]] <= 1'b1;
        end
        pipe[0] <= ram_rd(bus.mem_addr[7:0]);
        for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
    end
    assign bus.mem_rdata = pipe[RL-1];

    typedef struct {
        int          core;
        bit          chk;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int vectors     = 0;
    int miscompares = 0;
    int nrd = 0;
    int nwr = 0;
    int ack_cyc [NC];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endfunction

    // Monitor: pops the scoreboard on every ack bit
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.mem_rd === 1'b1) nrd++;
            if (bus.mem_wr === 1'b1) nwr++;
            for (int i = 0; i < NC; i++) begin
                if (bus.ack[i] === 1'b1) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_ack: core %0d acked, required no ack", i);
                    end else begin
                        e = sb.pop_front();
                        check("ack_core", 64'(i), 64'(e.core));
                        if (e.chk) check("rdata", bus.core_rdata[i*DW +: DW], e.data);
                    end
                end
            end
        end
    end

    task automatic set_rd(input int c, input logic [15:0] a);
        bus.core_addr[c*AW +: AW] = a;
        bus.req_rd[c] = 1'b1;
    endtask

    task automatic set_wr(input int c, input logic [15:0] a, input logic [15:0] d);
        bus.core_addr[c*AW +: AW]  = a;
        bus.core_wdata[c*DW +: DW] = d;
        bus.req_wr[c] = 1'b1;
    endtask

    task automatic push(input int c, input bit chk, input logic [15:0] d);
        sb.push_back('{core: c, chk: chk, data: d});
    endtask

    // Waits for every active requester to be acked, dropping its request on ack.
    task automatic go(input int budget);
        logic [NC-1:0] pend;
        int cyc;
        pend = bus.req_rd | bus.req_wr;
        cyc  = 0;
        for (int i = 0; i < NC; i++) ack_cyc[i] = -1;
        while (pend != '0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NC; i++) begin
                if (pend[i] && bus.ack[i] === 1'b1) begin
                    ack_cyc[i]    = cyc;
                    pend[i]       = 1'b0;
                    bus.req_rd[i] = 1'b0;
                    bus.req_wr[i] = 1'b0;
                end
            end
        end
        if (pend != '0) begin
            vectors++;
            miscompares++;
            $display("FAIL go_timeout: pending %b after %0d cycles, required none", pend, cyc);
            bus.req_rd = '0;
            bus.req_wr = '0;
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int w0;
        bus.req_rd     = '0;
        bus.req_wr     = '0;
        bus.core_addr  = '0;
        bus.core_wdata = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy",   bus.busy, 0);
        check("rst_ack",    bus.ack, 0);
        check("rst_rdata",  bus.core_rdata, 0);
        check("rst_mem_rd", bus.mem_rd, 0);
        check("rst_mem_wr", bus.mem_wr, 0);
        check("rst_addr",   bus.mem_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        // core2 write then read-back; leaves pointer at 3
        w0 = nwr;
        set_wr(2, 16'h0040, 16'hBEEF);
        push(2, 1'b0, 16'h0);
        go(100);
        check("wr_lat",    ack_cyc[2], 2);
        check("wr_pulses", nwr - w0, 1);
        check("ram_40",    ram_rd(8'h40), 16'hBEEF);
        r0 = nrd;
        set_rd(2, 16'h0040);
        push(2, 1'b1, 16'hBEEF);
        go(100);
        check("rd_lat",    ack_cyc[2], 2 + RL);
        check("rd_pulses", nrd - r0, 1);

        // pointer=3: core3 before core1
        set_rd(1, 16'h0011);
        set_rd(3, 16'h0013);
        push(3, 1'b1, 16'h5A13);
        push(1, 1'b1, 16'h5A11);
        go(100);
        check("wrap_c3_lat", ack_cyc[3], 2 + RL);
        check("wrap_c1_lat", ack_cyc[1], 2 * RL + 5);

        // read and write together: write wins
        r0 = nrd;
        w0 = nwr;
        set_rd(0, 16'h0020);
        set_wr(0, 16'h0020, 16'h1234);
        push(0, 1'b0, 16'h0);
        go(100);
        check("rw_wr_pulses", nwr - w0, 1);
        check("rw_rd_pulses", nrd - r0, 0);
        check("rw_lat",       ack_cyc[0], 2);
        check("ram_20",       ram_rd(8'h20), 16'h1234);
        set_rd(0, 16'h0020);
        push(0, 1'b1, 16'h1234);
        go(100);

        // cores 0 and 3 reading the same address, pointer=1
        r0 = nrd;
        set_rd(0, 16'h0080);
        set_rd(3, 16'h0080);
`ifdef DM_COALESCE_EN
        push(0, 1'b1, 16'h5A80);
        push(3, 1'b1, 16'h5A80);
        go(100);
        check("co_rd_pulses", nrd - r0, 1);
        check("co_c0_lat",    ack_cyc[0], 2 + RL);
        check("co_c3_lat",    ack_cyc[3], 2 + RL);
`else
        push(3, 1'b1, 16'h5A80);
        push(0, 1'b1, 16'h5A80);
        go(100);
        check("co_rd_pulses", nrd - r0, 2);
        check("co_c3_lat",    ack_cyc[3], 2 + RL);
        check("co_c0_lat",    ack_cyc[0], 2 * RL + 5);
`endif

        // reset during WAIT abandons the read
        set_rd(1, 16'h0012);
        @(negedge clk);
        check("iss_mem_rd", bus.mem_rd, 1);
        check("iss_busy",   bus.busy, 1);
        @(negedge clk);
        rst = 1'b1;
        bus.req_rd = '0;
        #1;
        check("mid_busy",   bus.busy, 0);
        check("mid_ack",    bus.ack, 0);
        check("mid_rdata",  bus.core_rdata, 0);
        check("mid_mem_rd", bus.mem_rd, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // all four cores read from reset: served 0..3, RL+3 cycles apart
        for (int i = 0; i < NC; i++) begin
            set_rd(i, 16'h0010 + 16'(i));
            push(i, 1'b1, 16'h5A10 + 16'(i));
        end
        go(200);
        for (int i = 0; i < NC; i++) check("all_lat", ack_cyc[i], 2 + RL + i * (RL + 3));

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
